// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU definitions: VRAM port FSM encoding and PPUCTRL bit positions
package ppu_pkg;

    // VRAM access sequencer states. A non-IDLE state means one VRAM request is outstanding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } vram_state_e;

    // PPUCTRL bit that selects the VRAM address increment (+1 or +row).
    // This bit is routed to the port's i_inc_sel input.
    localparam int PPUCTRL_INC_BIT = 2;

endpackage

// File: rtl/ppu_vram_port.sv
// rtl/ppu_vram_port.sv - CPU-side PPUADDR/PPUDATA port sequencing single VRAM accesses
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   i_inc_sel           PPUCTRL increment select (0: +1, 1: +INC_ROW)
//   i_addr_we/_byte     PPUADDR write strobe and byte (high byte first, via toggle w)
//   i_data_we/_byte     PPUDATA write strobe and byte
//   i_data_re           PPUDATA read strobe (returns buffered value, then refetches)
//   i_status_re         PPUSTATUS read strobe (clears the address toggle)
//   o_read_data         buffered PPUDATA read value
//   o_vram_addr/_wdata  VRAM address and write data
//   o_vram_we/_re       VRAM request, held until i_vram_ready
//   i_vram_rdata/_ready VRAM read data and accept/complete handshake
//   o_busy              a VRAM request is outstanding
//   o_overrun           sticky: a CPU access arrived that could not be served
module ppu_vram_port
    import ppu_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int INC_ROW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_inc_sel,
    input  logic              i_addr_we,
    input  logic [7:0]        i_addr_byte,
    input  logic              i_data_we,
    input  logic [7:0]        i_data_byte,
    input  logic              i_data_re,
    input  logic              i_status_re,
    output logic [7:0]        o_read_data,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_wdata,
    output logic              o_vram_we,
    output logic              o_vram_re,
    input  logic [7:0]        i_vram_rdata,
    input  logic              i_vram_ready,
    output logic              o_busy,
    output logic              o_overrun
);

    vram_state_e       state;
    vram_state_e       state_next;

    logic [ADDR_W-1:0] v;
    logic              w;
    logic [7:0]        rbuf;
    logic [7:0]        wdata;
    logic              overrun;

    logic              busy;
    logic              start_wr;
    logic              done;
    logic              overrun_set;
    logic [ADDR_W-1:0] step;

    // Upper PPUADDR bits beyond the VRAM address space are don't-care.
    if (ADDR_W < 16) begin : g_addr_hi_unused
        logic unused_addr_hi;
        assign unused_addr_hi = &{1'b0, i_addr_byte[7:ADDR_W-8]};
    end

    // Next-state and per-cycle control decode
    always_comb begin
        state_next = state;
        start_wr   = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                // A write wins over a simultaneous read; the read is dropped.
                if (i_data_we) begin
                    start_wr   = 1'b1;
                    state_next = ST_WRITE;
                end else if (i_data_re) begin
                    state_next = ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                if (i_vram_ready) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        overrun_set = (busy && (i_data_we || i_data_re || i_addr_we)) ||
                      (!busy && i_data_we && i_data_re);
        step = i_inc_sel ? ADDR_W'(INC_ROW) : ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address, toggle, buffers and sticky flag
    always_ff @(posedge clk) begin
        if (reset) begin
            v       <= '0;
            w       <= 1'b0;
            rbuf    <= 8'h00;
            wdata   <= 8'h00;
            overrun <= 1'b0;
        end else begin
            if (start_wr) begin
                wdata <= i_data_byte;
            end
            if (done && state == ST_READ) begin
                rbuf <= i_vram_rdata;
            end
            // v cannot be loaded while busy, so completion and load never collide.
            if (done) begin
                v <= v + step;
            end else if (i_addr_we && !busy) begin
                if (!w) begin
                    v[ADDR_W-1:8] <= i_addr_byte[ADDR_W-9:0];
                end else begin
                    v[7:0] <= i_addr_byte;
                end
            end
            // A status read overrides the toggle flip of a coincident address write.
            if (i_status_re) begin
                w <= 1'b0;
            end else if (i_addr_we && !busy) begin
                w <= ~w;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    assign o_read_data  = rbuf;
    assign o_vram_addr  = v;
    assign o_vram_wdata = wdata;
    assign o_vram_we    = (state == ST_WRITE);
    assign o_vram_re    = (state == ST_READ);
    assign o_busy       = busy;
    assign o_overrun    = overrun;

endmodule

// File: tb/tb_ppu_vram_port.sv
// tb/tb_ppu_vram_port.sv - scoreboard bench for ppu_vram_port
module tb_ppu_vram_port;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_inc_sel;
    logic        i_addr_we;
    logic [7:0]  i_addr_byte;
    logic        i_data_we;
    logic [7:0]  i_data_byte;
    logic        i_data_re;
    logic        i_status_re;
    logic [7:0]  o_read_data;
    logic [13:0] o_vram_addr;
    logic [7:0]  o_vram_wdata;
    logic        o_vram_we;
    logic        o_vram_re;
    logic [7:0]  i_vram_rdata;
    logic        i_vram_ready;
    logic        o_busy;
    logic        o_overrun;

    logic [7:0]  vram [0:16383];
    txn_t        exp_q[$];
    logic [7:0]  rd_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign i_vram_rdata = vram[o_vram_addr];

    ppu_vram_port #(.ADDR_W(14), .INC_ROW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_inc_sel    (i_inc_sel),
        .i_addr_we    (i_addr_we),
        .i_addr_byte  (i_addr_byte),
        .i_data_we    (i_data_we),
        .i_data_byte  (i_data_byte),
        .i_data_re    (i_data_re),
        .i_status_re  (i_status_re),
        .o_read_data  (o_read_data),
        .o_vram_addr  (o_vram_addr),
        .o_vram_wdata (o_vram_wdata),
        .o_vram_we    (o_vram_we),
        .o_vram_re    (o_vram_re),
        .i_vram_rdata (i_vram_rdata),
        .i_vram_ready (i_vram_ready),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic addr_write(input logic [7:0] b);
        i_addr_we   = 1'b1;
        i_addr_byte = b;
        tick();
        i_addr_we   = 1'b0;
    endtask

    task automatic set_addr(input logic [15:0] a);
        addr_write(a[15:8]);
        addr_write(a[7:0]);
    endtask

    task automatic cpu_write(input logic [13:0] exp_addr, input logic [7:0] b);
        exp_q.push_back({1'b1, exp_addr, b});
        i_data_we   = 1'b1;
        i_data_byte = b;
        tick();
        i_data_we   = 1'b0;
    endtask

    // Returns the value the CPU sees on o_read_data during the strobe cycle.
    task automatic cpu_read(input logic [13:0] exp_addr, output logic [7:0] seen);
        exp_q.push_back({1'b0, exp_addr, 8'h00});
        i_data_re = 1'b1;
        seen      = o_read_data;
        tick();
        i_data_re = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_vram_we || o_vram_re) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic capture(output txn_t got);
        got.we   = o_vram_we;
        got.addr = o_vram_addr;
        got.data = o_vram_we ? o_vram_wdata : 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({o_read_data, o_vram_addr, o_vram_wdata, o_vram_we, o_vram_re, o_busy, o_overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got rd=%h addr=%h wd=%h we=%b re=%b busy=%b ovr=%b exp all zero",
                     o_read_data, o_vram_addr, o_vram_wdata, o_vram_we, o_vram_re, o_busy, o_overrun);
        end
    endtask

    task automatic test_read_buffer();
        bit ok;
        txn_t got, e;
        logic [7:0] seen, er;
        vram[14'h2000] = 8'h55;
        vram[14'h2001] = 8'h66;
        i_vram_ready = 1'b1;
        set_addr(16'h2000);
        rd_q.push_back(8'h00);
        rd_q.push_back(8'h55);
        for (int k = 0; k < 2; k++) begin
            cpu_read(14'h2000 + 14'(k), seen);
            er = rd_q.pop_front();
            n_cmp++;
            if (seen !== er) begin
                n_bad++;
                $display("FAIL read_buffer_%0d got=%h exp=%h", k, seen, er);
            end
            wait_req(ok);
            capture(got);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== e) begin
                n_bad++;
                $display("FAIL read_req_%0d got=%h exp=%h ok=%b", k, got, e, ok);
            end
            tick();
        end
        n_cmp++;
        if (o_vram_addr !== 14'h2002 || o_read_data !== 8'h66) begin
            n_bad++;
            $display("FAIL read_after got addr=%h rd=%h exp addr=2002 rd=66", o_vram_addr, o_read_data);
        end
    endtask

    task automatic test_write_basic();
        bit ok;
        txn_t got, e;
        i_vram_ready = 1'b1;
        set_addr(16'h2108);
        cpu_write(14'h2108, 8'hAB);
        wait_req(ok);
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== e) begin
            n_bad++;
            $display("FAIL write_basic got=%h exp=%h ok=%b", got, e, ok);
        end
        tick();
        n_cmp++;
        if (o_vram_we !== 1'b0 || o_busy !== 1'b0 || o_vram_addr !== 14'h2109) begin
            n_bad++;
            $display("FAIL write_basic_after got we=%b busy=%b addr=%h exp we=0 busy=0 addr=2109",
                     o_vram_we, o_busy, o_vram_addr);
        end
    endtask

    task automatic test_write_wait();
        bit ok, hold_ok;
        txn_t got, e;
        i_inc_sel    = 1'b1;
        i_vram_ready = 1'b0;
        set_addr(16'h3FE0);
        cpu_write(14'h3FE0, 8'h77);
        wait_req(ok);
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== e) begin
            n_bad++;
            $display("FAIL write_wait_req got=%h exp=%h ok=%b", got, e, ok);
        end
        hold_ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (o_vram_we !== 1'b1 || o_vram_addr !== 14'h3FE0 || o_vram_wdata !== 8'h77)
                hold_ok = 1'b0;
            if (k == 2) i_vram_ready = 1'b1;
            tick();
        end
        n_cmp++;
        if (!hold_ok) begin
            n_bad++;
            $display("FAIL write_wait_hold got=0 exp=1");
        end
        n_cmp++;
        if (o_vram_we !== 1'b0 || o_vram_addr !== 14'h0000) begin
            n_bad++;
            $display("FAIL write_wait_wrap got we=%b addr=%h exp we=0 addr=0000", o_vram_we, o_vram_addr);
        end
        i_inc_sel = 1'b0;
    endtask

    task automatic test_wrap_plus1();
        bit ok;
        txn_t got, e;
        i_vram_ready = 1'b1;
        set_addr(16'h3FFF);
        cpu_write(14'h3FFF, 8'h5A);
        wait_req(ok);
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== e) begin
            n_bad++;
            $display("FAIL wrap1_req got=%h exp=%h ok=%b", got, e, ok);
        end
        tick();
        n_cmp++;
        if (o_vram_addr !== 14'h0000) begin
            n_bad++;
            $display("FAIL wrap1_addr got=%h exp=0000", o_vram_addr);
        end
    endtask

    task automatic test_status_toggle();
        do_reset();
        addr_write(8'h23);
        i_status_re = 1'b1;
        tick();
        i_status_re = 1'b0;
        addr_write(8'h04);
        n_cmp++;
        if (o_vram_addr[13:8] !== 6'h04) begin
            n_bad++;
            $display("FAIL status_hi_reload got=%h exp=04", o_vram_addr[13:8]);
        end
        addr_write(8'h10);
        n_cmp++;
        if (o_vram_addr !== 14'h0410) begin
            n_bad++;
            $display("FAIL status_w_set got=%h exp=0410", o_vram_addr);
        end
        // coincident status read with w=0: high byte loads, w stays 0
        i_addr_we = 1'b1; i_addr_byte = 8'h12; i_status_re = 1'b1;
        tick();
        i_addr_we = 1'b0; i_status_re = 1'b0;
        addr_write(8'h34);
        addr_write(8'h56);
        n_cmp++;
        if (o_vram_addr !== 14'h3456) begin
            n_bad++;
            $display("FAIL status_coincide_w0 got=%h exp=3456", o_vram_addr);
        end
        // coincident status read with w=1: low byte loads, then w forced 0
        addr_write(8'h11);
        i_addr_we = 1'b1; i_addr_byte = 8'h22; i_status_re = 1'b1;
        tick();
        i_addr_we = 1'b0; i_status_re = 1'b0;
        addr_write(8'h05);
        n_cmp++;
        if (o_vram_addr !== 14'h0522) begin
            n_bad++;
            $display("FAIL status_coincide_w1 got=%h exp=0522", o_vram_addr);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        txn_t got, e;
        logic [7:0] seen;
        do_reset();
        vram[14'h0100] = 8'h3C;
        i_vram_ready = 1'b0;
        set_addr(16'h0100);
        cpu_read(14'h0100, seen);
        wait_req(ok);
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== e) begin
            n_bad++;
            $display("FAIL overrun_read_req got=%h exp=%h ok=%b", got, e, ok);
        end
        i_data_we = 1'b1; i_data_byte = 8'h99;
        tick();
        i_data_we = 1'b0;
        n_cmp++;
        if (o_overrun !== 1'b1 || o_vram_re !== 1'b1 || o_vram_we !== 1'b0 || o_vram_addr !== 14'h0100) begin
            n_bad++;
            $display("FAIL overrun_flag got ovr=%b re=%b we=%b addr=%h exp ovr=1 re=1 we=0 addr=0100",
                     o_overrun, o_vram_re, o_vram_we, o_vram_addr);
        end
        i_vram_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (o_vram_we !== 1'b0 || o_busy !== 1'b0 || o_read_data !== 8'h3C || o_vram_addr !== 14'h0101) begin
            n_bad++;
            $display("FAIL overrun_ignored got we=%b busy=%b rd=%h addr=%h exp we=0 busy=0 rd=3c addr=0101",
                     o_vram_we, o_busy, o_read_data, o_vram_addr);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        txn_t got, e;
        i_vram_ready = 1'b0;
        set_addr(16'h0000);
        cpu_write(14'h0000, 8'h42);
        wait_req(ok);
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== e) begin
            n_bad++;
            $display("FAIL rst_mid_req got=%h exp=%h ok=%b", got, e, ok);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (o_vram_we !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_vram_addr !== 14'h0000) begin
            n_bad++;
            $display("FAIL rst_mid_abandon got we=%b busy=%b ovr=%b addr=%h exp we=0 busy=0 ovr=0 addr=0000",
                     o_vram_we, o_busy, o_overrun, o_vram_addr);
        end
        i_vram_ready = 1'b1;
        tick();
        n_cmp++;
        if (o_vram_we !== 1'b0 || o_vram_addr !== 14'h0000) begin
            n_bad++;
            $display("FAIL rst_mid_no_inc got we=%b addr=%h exp we=0 addr=0000", o_vram_we, o_vram_addr);
        end
    endtask

    task automatic test_collision();
        txn_t got, e;
        do_reset();
        i_vram_ready = 1'b1;
        set_addr(16'h0100);
        exp_q.push_back({1'b1, 14'h0100, 8'hC3});
        i_data_we = 1'b1; i_data_re = 1'b1; i_data_byte = 8'hC3;
        tick();
        i_data_we = 1'b0; i_data_re = 1'b0;
        capture(got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e || o_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL collision_write got=%h ovr=%b exp=%h ovr=1", got, o_overrun, e);
        end
        tick();
        n_cmp++;
        if (o_vram_re !== 1'b0 || o_vram_we !== 1'b0 || o_vram_addr !== 14'h0101) begin
            n_bad++;
            $display("FAIL collision_no_read got re=%b we=%b addr=%h exp re=0 we=0 addr=0101",
                     o_vram_re, o_vram_we, o_vram_addr);
        end
    endtask

    initial begin
        reset        = 1'b1;
        i_inc_sel    = 1'b0;
        i_addr_we    = 1'b0;
        i_addr_byte  = 8'h00;
        i_data_we    = 1'b0;
        i_data_byte  = 8'h00;
        i_data_re    = 1'b0;
        i_status_re  = 1'b0;
        i_vram_ready = 1'b0;
        for (int i = 0; i < 16384; i++) vram[i] = 8'(i * 7);

        test_reset();
        test_read_buffer();
        test_write_basic();
        test_write_wait();
        test_wrap_plus1();
        test_status_toggle();
        test_overrun();
        test_reset_mid_write();
        test_collision();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
